// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one asynchronous-read data memory port between
// the CPU data interface and the debug interface. Grants are combinational,
// and each access completes in its grant cycle. Read data is registered and
// returned with a one-cycle rvalid pulse. A debug requester holding dbg_lock
// keeps ownership. If the CPU is also waiting, it gets one forced beat after
// LOCK_MAX locked debug beats.
//
// Build option: define ARB_ROUND_ROBIN_EN to resolve unlocked conflicts
// round-robin. If it is not defined, the CPU wins unlocked conflicts and no
// last-winner register is built.
module data_mem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  // CPU data port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  // Debug port
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_lock,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [3:0]  dbg_wmask,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  // Shared memory port
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // The state records which requester owned the previous granted beat.
  typedef enum logic [1:0] {IDLE, CPU_OWN, DBG_OWN, DBG_LOCKED} state_t;

  localparam int              CW         = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]   LOCK_MAX_C = CW'(LOCK_MAX);

  state_t        state, state_nxt;
  logic [CW-1:0] lock_cnt;
  logic          in_lock;    // locked owner is still requesting this cycle
  logic          lock_full;  // the CPU has waited through LOCK_MAX locked beats
  logic          force_cpu;  // this CPU grant preempts a lock

`ifdef ARB_ROUND_ROBIN_EN
  logic          last_dbg;   // 1 when debug won the most recent granted beat
`endif

  assign in_lock   = (state == DBG_LOCKED) && dbg_req;
  assign lock_full = (lock_cnt == LOCK_MAX_C);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, whatever the process order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state follows the owner of this cycle's grant. The exception is a
  // forced CPU beat, which hands ownership back to a lock that is still held.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = IDLE;
    if (dbg_gnt)      state_nxt = dbg_lock ? DBG_LOCKED : DBG_OWN;
    else if (cpu_gnt) state_nxt = (force_cpu && dbg_lock) ? DBG_LOCKED : CPU_OWN;
  end

  // Output logic: choose the grant winner, then steer the winner onto the
  // memory port.
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    force_cpu = 1'b0;
    mem_we    = 1'b0;
    mem_wmask = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;

    if (!reset) begin
      if (in_lock) begin
        if (cpu_req && lock_full) begin
          cpu_gnt   = 1'b1;
          force_cpu = 1'b1;
        end else begin
          dbg_gnt = 1'b1;
        end
      end else if (cpu_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_dbg) cpu_gnt = 1'b1;
        else          dbg_gnt = 1'b1;
`else
        cpu_gnt = 1'b1;
`endif
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end

    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_wmask = cpu_we ? cpu_wmask : 4'h0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_wmask = dbg_we ? dbg_wmask : 4'h0;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Lock counter: counts locked debug beats that the CPU waited through.
  // It clears when the CPU gets a beat or when the lock is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt <= '0;
    end else if (cpu_gnt || (state_nxt != DBG_LOCKED)) begin
      lock_cnt <= '0;
    end else if (in_lock && dbg_gnt && cpu_req && !lock_full) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-winner register for round-robin. Reset favours the CPU on the first
  // conflict.
  always_ff @(posedge clk) begin
    if (reset)        last_dbg <= 1'b1;
    else if (dbg_gnt) last_dbg <= 1'b1;
    else if (cpu_gnt) last_dbg <= 1'b0;
  end
`endif

  // Read-return path: capture memory data on a read grant and pulse rvalid
  // in the following cycle. rdata holds its value until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= 32'h0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= 32'h0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dbg_rvalid <= dbg_gnt && !dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter (default LOCK_MAX = 16).
// It runs a per-cycle vector table, then hand-written lock and reset
// sequences. Expected values follow ARB_ROUND_ROBIN_EN when that macro is set.
module tb_data_mem_arbiter;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wmask;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_wmask;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wmask(dbg_wmask),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic [3:0]  cwm;
    logic        dreq, dwe, dlock;
    logic [31:0] daddr, dwd;
    logic [3:0]  dwm;
    logic [31:0] mrd;
    logic        e_cg, e_dg, e_we;
    logic [3:0]  e_wm;
    logic [31:0] e_ad, e_wd;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, creq, cwe, input logic [31:0] caddr, cwd, input logic [3:0] cwm,
    input logic dreq, dwe, dlock, input logic [31:0] daddr, dwd, input logic [3:0] dwm,
    input logic [31:0] mrd,
    input logic cg, dg, we, input logic [3:0] wm, input logic [31:0] ad, wd,
    input logic crv, input logic [31:0] crd, input logic drv, input logic [31:0] drd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd; v.cwm = cwm;
    v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwd = dwd; v.dwm = dwm;
    v.mrd = mrd;
    v.e_cg = cg; v.e_dg = dg; v.e_we = we; v.e_wm = wm; v.e_ad = ad; v.e_wd = wd;
    v.e_crv = crv; v.e_crd = crd; v.e_drv = drv; v.e_drd = drd;
    return v;
  endfunction

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge so the outputs can be sampled.
  task automatic cyc(input logic rst, creq, cwe, dreq, dwe, dlock);
    @(posedge clk); #1;
    reset = rst;
    cpu_req = creq; cpu_we = cwe; cpu_addr = 32'h100; cpu_wdata = 32'hC1C1C1C1; cpu_wmask = 4'hF;
    dbg_req = dreq; dbg_we = dwe; dbg_lock = dlock; dbg_addr = 32'h200;
    dbg_wdata = 32'hD2D2D2D2; dbg_wmask = 4'hF; mem_rdata = 32'h0;
    @(negedge clk);
  endtask

  vec_t vecs[14];

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_wmask = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset with requests pending: no grants and an idle memory port.
    vecs[0]  = mk(I, I,O,32'h10,32'hC0C00001,4'hF, I,I,O,32'h20,32'h1234,4'h3, '0,
                  O,O,O,'0,'0,'0, O,'0, O,'0);
    // CPU read of 0x10 returning 0xDEADBEEF; the read forces mem_wmask to 0.
    vecs[1]  = mk(O, I,O,32'h10,'0,4'hF, O,O,O,'0,'0,'0, 32'hDEADBEEF,
                  I,O,O,'0,32'h10,'0, O,'0, O,'0);
    // Debug write to 0x20 (mask 0x3); the CPU read data returns this cycle.
    vecs[2]  = mk(O, O,O,'0,'0,'0, I,I,O,32'h20,32'h1234,4'h3, 32'h0BAD0BAD,
                  O,I,I,4'h3,32'h20,32'h1234, I,32'hDEADBEEF, O,'0);
    // Idle: the debug write must not produce rvalid, and rdata holds.
    vecs[3]  = mk(O, O,O,'0,'0,'0, O,O,O,'0,'0,'0, 32'h13572468,
                  O,O,O,'0,'0,'0, O,32'hDEADBEEF, O,'0);
    // Debug read of 0x24.
    vecs[4]  = mk(O, O,O,'0,'0,'0, I,O,O,32'h24,'0,4'hF, 32'hA5A50001,
                  O,I,O,'0,32'h24,'0, O,32'hDEADBEEF, O,'0);
    vecs[5]  = mk(O, O,O,'0,'0,'0, O,O,O,'0,'0,'0, '0,
                  O,O,O,'0,'0,'0, O,32'hDEADBEEF, I,32'hA5A50001);
    // CPU write: the memory read data must not be captured.
    vecs[6]  = mk(O, I,I,32'h30,32'h55AA55AA,4'hC, O,O,O,'0,'0,'0, 32'hFFFF0000,
                  I,O,I,4'hC,32'h30,32'h55AA55AA, O,32'hDEADBEEF, O,32'hA5A50001);
    vecs[7]  = mk(O, O,O,'0,'0,'0, O,O,O,'0,'0,'0, '0,
                  O,O,O,'0,'0,'0, O,32'hDEADBEEF, O,32'hA5A50001);
    // Reset that clears the rdata registers and the last winner.
    vecs[8]  = mk(I, O,O,'0,'0,'0, O,O,O,'0,'0,'0, '0,
                  O,O,O,'0,'0,'0, O,32'hDEADBEEF, O,32'hA5A50001);
    // Four conflict cycles without lock: round-robin gives C,D,C,D; fixed gives C x4.
    vecs[9]  = mk(O, I,I,32'h40,32'h11111111,4'hF, I,I,O,32'h50,32'h22222222,4'h5, '0,
                  I,O,I,4'hF,32'h40,32'h11111111, O,'0, O,'0);
    vecs[10] = mk(O, I,I,32'h40,32'h11111111,4'hF, I,I,O,32'h50,32'h22222222,4'h5, '0,
                  ~RR,RR,I,RR ? 4'h5 : 4'hF,RR ? 32'h50 : 32'h40,
                  RR ? 32'h22222222 : 32'h11111111, O,'0, O,'0);
    vecs[11] = vecs[9];
    vecs[12] = vecs[10];
    vecs[13] = mk(O, O,O,'0,'0,'0, O,O,O,'0,'0,'0, '0,
                  O,O,O,'0,'0,'0, O,'0, O,'0);

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      reset = vecs[i].rst;
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr;
      cpu_wdata = vecs[i].cwd; cpu_wmask = vecs[i].cwm;
      dbg_req = vecs[i].dreq; dbg_we = vecs[i].dwe; dbg_lock = vecs[i].dlock;
      dbg_addr = vecs[i].daddr; dbg_wdata = vecs[i].dwd; dbg_wmask = vecs[i].dwm;
      mem_rdata = vecs[i].mrd;
      @(negedge clk);
      check_b($sformatf("v%0d cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
      check_b($sformatf("v%0d dbg_gnt", i), dbg_gnt, vecs[i].e_dg);
      check_b($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
      check_w($sformatf("v%0d mem_wmask", i), 32'(mem_wmask), 32'(vecs[i].e_wm));
      check_w($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_ad);
      check_w($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wd);
      check_b($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
      check_w($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      check_b($sformatf("v%0d dbg_rvalid", i), dbg_rvalid, vecs[i].e_drv);
      check_w($sformatf("v%0d dbg_rdata", i), dbg_rdata, vecs[i].e_drd);
    end

    // Lock starvation bound: enter the lock, then expect 16 debug beats,
    // 1 forced CPU beat, and the same pattern again.
    cyc(I, O,O, O,O,O);
    cyc(O, O,O, I,I,I);
    check_b("lock_entry dbg_gnt", dbg_gnt, I);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 16; k++) begin
        cyc(O, I,I, I,I,I);
        check_b($sformatf("lock r%0d beat%0d dbg_gnt", r, k), dbg_gnt, I);
        check_b($sformatf("lock r%0d beat%0d cpu_gnt", r, k), cpu_gnt, O);
      end
      cyc(O, I,I, I,I,I);
      check_b($sformatf("lock r%0d forced cpu_gnt", r), cpu_gnt, I);
      check_b($sformatf("lock r%0d forced dbg_gnt", r), dbg_gnt, O);
    end

    // A locked owner with no request falls back to unlocked arbitration,
    // so the CPU read is granted.
    cyc(O, I,O, O,O,I);
    check_b("lock_idle cpu_gnt", cpu_gnt, I);
    check_b("lock_idle dbg_gnt", dbg_gnt, O);
    // The state is now CPU_OWN. A conflict goes to debug under round-robin
    // and to the CPU under fixed priority.
    cyc(O, I,I, I,I,I);
    check_b("post_lock conflict dbg_gnt", dbg_gnt, RR);
    check_b("post_lock cpu_rvalid", cpu_rvalid, I);

    // Reset during a locked debug read: no grant in the reset cycle, no
    // rvalid afterwards, and the state returns to IDLE.
    cyc(I, O,O, O,O,O);
    cyc(O, O,O, I,I,I);
    check_b("rst_lock entry dbg_gnt", dbg_gnt, I);
    cyc(I, O,O, I,O,I);
    check_b("rst_lock dbg_gnt", dbg_gnt, O);
    check_b("rst_lock cpu_gnt", cpu_gnt, O);
    check_b("rst_lock mem_we", mem_we, O);
    cyc(O, O,O, O,O,O);
    check_b("rst_lock dbg_rvalid", dbg_rvalid, O);
    check_b("rst_lock cpu_rvalid", cpu_rvalid, O);
    cyc(O, I,I, I,I,I);
    check_b("rst_lock idle conflict cpu_gnt", cpu_gnt, I);
    check_b("rst_lock idle conflict dbg_gnt", dbg_gnt, O);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
